// File: rtl/bullet_controller.sv
// Single player-bullet slot: launches from the muzzle on a frame tick, climbs
// once per frame, retires on hit or at the top, then waits out a cooldown.
module bullet_controller #(
    parameter int BULLET_SPEED    = 4,
    parameter int BULLET_LEN      = 4,
    parameter int MUZZLE_OFFSET   = 12,
    parameter int TOP_Y           = 0,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       game_active,
    input  logic       fire,
    input  logic [9:0] playerX,
    input  logic [9:0] playerY,
    input  logic       hit,
    output logic       bullet_in,
    output logic [9:0] bulletX,
    output logic [9:0] bulletY,
    output logic       fired,
    output logic       score_pulse
);

    localparam int         CNT_W    = 8;
    localparam logic [9:0] SPEED    = 10'(BULLET_SPEED);
    localparam logic [9:0] LEN      = 10'(BULLET_LEN);
    localparam logic [9:0] MUZZLE   = 10'(MUZZLE_OFFSET);
    localparam logic [9:0] EXPIRE_Y = 10'(TOP_Y + BULLET_SPEED);
    localparam logic [CNT_W-1:0] CD_LOAD = CNT_W'(COOLDOWN_FRAMES);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLIGHT   = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [9:0]       x_n, y_n;
    logic             fired_n, score_n;
    logic             s1, s2, s3;
    logic             frame_tick;

    // frame_clk is from the video domain: two-flop sync, then rising-edge detect
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= frame_clk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign frame_tick = s2 & ~s3;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            cnt         <= '0;
            bulletX     <= '0;
            bulletY     <= '0;
            bullet_in   <= 1'b0;
            fired       <= 1'b0;
            score_pulse <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            bulletX     <= x_n;
            bulletY     <= y_n;
            bullet_in   <= (state_n == FLIGHT);
            fired       <= fired_n;
            score_pulse <= score_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        x_n     = bulletX;
        y_n     = bulletY;
        fired_n = 1'b0;
        score_n = 1'b0;
        if (!game_active) begin
            // leaving play overrides everything; position is left as-is
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (frame_tick && fire) begin
                        state_n = FLIGHT;
                        x_n     = playerX + MUZZLE;
                        y_n     = (playerY >= LEN) ? playerY - LEN : '0;
                        fired_n = 1'b1;
                    end
                end
                FLIGHT: begin
                    if (hit) begin
                        state_n = COOLDOWN;
                        cnt_n   = CD_LOAD;
                        score_n = 1'b1;
                    end else if (frame_tick) begin
                        // compare before subtracting so bulletY never wraps
                        if (bulletY < EXPIRE_Y) begin
                            state_n = COOLDOWN;
                            cnt_n   = CD_LOAD;
                        end else begin
                            y_n = bulletY - SPEED;
                        end
                    end
                end
                COOLDOWN: begin
                    if (frame_tick) begin
                        if (cnt == '0) state_n = IDLE;
                        else           cnt_n   = cnt - 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bullet_controller.sv
// Directed bench for bullet_controller; launches and hits are scoreboarded
// against queues filled when the stimulus is driven.
module tb_bullet_controller;

    localparam int S_IDLE = 0, S_FLIGHT = 1, S_COOLDOWN = 2;

    logic       Clk = 1'b0;
    logic       Reset, frame_clk, game_active, fire, hit;
    logic [9:0] playerX, playerY;
    logic       bullet_in, fired, score_pulse;
    logic [9:0] bulletX, bulletY;
    logic       bullet_in0, fired0, score_pulse0;
    logic [9:0] bulletX0, bulletY0;

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
    } launch_t;

    launch_t    exp_launch[$];
    logic [9:0] exp_score[$];

    always #5 Clk = ~Clk;

    bullet_controller dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .game_active(game_active),
        .fire(fire), .playerX(playerX), .playerY(playerY), .hit(hit),
        .bullet_in(bullet_in), .bulletX(bulletX), .bulletY(bulletY),
        .fired(fired), .score_pulse(score_pulse)
    );

    bullet_controller #(.COOLDOWN_FRAMES(0)) dut0 (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .game_active(game_active),
        .fire(fire), .playerX(playerX), .playerY(playerY), .hit(hit),
        .bullet_in(bullet_in0), .bulletX(bulletX0), .bulletY(bulletY0),
        .fired(fired0), .score_pulse(score_pulse0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // scoreboard side: every fired / score_pulse must match a queued expectation
    always @(negedge Clk) begin
        if (!Reset && fired) begin
            if (exp_launch.size() == 0) chk("unexpected_fired", fired, 0);
            else begin
                launch_t e;
                e = exp_launch.pop_front();
                chk("launch_x", bulletX, e.x);
                chk("launch_y", bulletY, e.y);
                chk("launch_vis", bullet_in, 1);
            end
        end
        if (!Reset && score_pulse) begin
            if (exp_score.size() == 0) chk("unexpected_score", score_pulse, 0);
            else begin
                logic [9:0] ey;
                ey = exp_score.pop_front();
                chk("score_y_held", bulletY, ey);
                chk("score_vis", bullet_in, 0);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // one frame_clk pulse; h places hit in the same cycle frame_tick is seen
    task automatic tick_ev(input logic h);
        frame_clk = 1'b1;
        cyc(2);
        hit = h;
        cyc(1);
        hit = 1'b0;
        frame_clk = 1'b0;
        cyc(3);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick_ev(1'b0);
    endtask

    task automatic launch(input logic [9:0] px, input logic [9:0] py, input logic [9:0] ex, input logic [9:0] ey);
        playerX = px;
        playerY = py;
        fire = 1'b1;
        exp_launch.push_back('{x: ex, y: ey});
        tick_ev(1'b0);
        chk("launch_drained", exp_launch.size(), 0);
    endtask

    task automatic hit_pulse();
        exp_score.push_back(bulletY);
        hit = 1'b1;
        cyc(1);
        hit = 1'b0;
        chk("hit_drop_vis", bullet_in, 0);
        chk("hit_state", dut.state, S_COOLDOWN);
        cyc(1);
        chk("score_one_cycle", score_pulse, 0);
    endtask

    initial begin
        Reset = 1'b1; frame_clk = 1'b0; game_active = 1'b0; fire = 1'b0; hit = 1'b0;
        playerX = '0; playerY = '0;
        cyc(3);
        chk("rst_vis", bullet_in, 0);
        chk("rst_x", bulletX, 0);
        chk("rst_y", bulletY, 0);
        chk("rst_fired", fired, 0);
        chk("rst_state", dut.state, S_IDLE);
        Reset = 1'b0;
        game_active = 1'b1;
        cyc(2);

        // launch and flight
        launch(10'd300, 10'd440, 10'd312, 10'd436);
        chk("flight_state", dut.state, S_FLIGHT);
        ticks(3);
        chk("flight_y", bulletY, 424);
        chk("flight_x_frozen", bulletX, 312);
        chk("flight_vis", bullet_in, 1);
        fire = 1'b0;

        // hit in flight, then hits ignored in COOLDOWN and IDLE
        hit_pulse();
        hit = 1'b1; cyc(1); hit = 1'b0; cyc(1);
        chk("cd_hit_ignored", dut.state, S_COOLDOWN);
        ticks(8);
        chk("cd_still", dut.state, S_COOLDOWN);
        ticks(1);
        chk("cd_exit", dut.state, S_IDLE);
        hit = 1'b1; cyc(1); hit = 1'b0; cyc(1);
        chk("idle_hit_ignored", dut.state, S_IDLE);
        chk("idle_vis", bullet_in, 0);

        // asynchronous reset mid-flight
        launch(10'd50, 10'd104, 10'd62, 10'd100);
        fire = 1'b0;
        chk("pre_rst_y", bulletY, 100);
        Reset = 1'b1;
        #1;
        chk("arst_vis", bullet_in, 0);
        chk("arst_x", bulletX, 0);
        chk("arst_y", bulletY, 0);
        cyc(2);
        Reset = 1'b0;
        cyc(1);
        chk("post_rst_state", dut.state, S_IDLE);
        ticks(1);
        chk("post_rst_no_fire", dut.state, S_IDLE);

        // expiry at the top, then a held fire waits out the cooldown
        launch(10'd100, 10'd10, 10'd112, 10'd6);
        ticks(1);
        chk("exp_y2", bulletY, 2);
        chk("exp_vis_before", bullet_in, 1);
        ticks(1);
        chk("exp_vis", bullet_in, 0);
        chk("exp_state", dut.state, S_COOLDOWN);
        chk("exp_y_no_wrap", bulletY, 2);
        ticks(9);
        chk("refire_idle", dut.state, S_IDLE);
        exp_launch.push_back('{x: 10'd112, y: 10'd6});
        ticks(1);
        chk("refire_drained", exp_launch.size(), 0);
        fire = 1'b0;
        hit_pulse();
        ticks(9);

        // hit and frame_tick in the same cycle: hit wins, no move
        launch(10'd20, 10'd204, 10'd32, 10'd200);
        fire = 1'b0;
        exp_score.push_back(10'd200);
        tick_ev(1'b1);
        chk("sim_y", bulletY, 200);
        chk("sim_state", dut.state, S_COOLDOWN);
        chk("sim_score_drained", exp_score.size(), 0);
        ticks(9);

        // game_active drop with hit: no score, IDLE, position held
        launch(10'd40, 10'd300, 10'd52, 10'd296);
        fire = 1'b0;
        game_active = 1'b0; hit = 1'b1;
        cyc(1);
        hit = 1'b0;
        chk("ga_state", dut.state, S_IDLE);
        chk("ga_vis", bullet_in, 0);
        chk("ga_y_held", bulletY, 296);
        cyc(1);

        // game_active low blocks a launch
        fire = 1'b1;
        ticks(1);
        chk("ga_no_launch", dut.state, S_IDLE);
        game_active = 1'b1;
        fire = 1'b0;
        cyc(2);

        // boundaries: X wrap, Y clamp, immediate expiry, zero cooldown
        launch(10'd1020, 10'd2, 10'd8, 10'd0);
        fire = 1'b0;
        chk("bnd_vis0", bullet_in0, 1);
        chk("bnd_y0", bulletY0, 0);
        ticks(1);
        chk("bnd_expire", bullet_in, 0);
        chk("bnd_state", dut.state, S_COOLDOWN);
        ticks(1);
        chk("cd0_idle", dut0.state, S_IDLE);
        chk("cd8_busy", dut.state, S_COOLDOWN);

        cyc(4);
        chk("end_launch_q", exp_launch.size(), 0);
        chk("end_score_q", exp_score.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
